// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: allocates scoreboard slots in issue order, records
// out-of-order writeback completion, and retires the oldest finished slot
// in order. A flush squashes every uncommitted slot.
`timescale 1ns/1ps
module scoreboard_ctrl #(
    parameter int SB_ENTRIES = 8,
    parameter int IDX_W      = $clog2(SB_ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             alloc_valid_i,
    output logic             alloc_ready_o,
    output logic [IDX_W-1:0] alloc_idx_o,
    input  logic             wb_valid_i,
    input  logic [IDX_W-1:0] wb_idx_i,
    input  logic             wb_ex_i,
    output logic             commit_valid_o,
    output logic [IDX_W-1:0] commit_idx_o,
    output logic             commit_ex_o,
    input  logic             commit_ack_i,
    output logic [IDX_W:0]   count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(SB_ENTRIES);

    logic [IDX_W-1:0]      issue_ptr;
    logic [IDX_W-1:0]      commit_ptr;
    logic [IDX_W:0]        cnt;
    logic [SB_ENTRIES-1:0] busy;
    logic [SB_ENTRIES-1:0] done;
    logic [SB_ENTRIES-1:0] ex;

    logic alloc_fire;
    logic commit_fire;
    logic wb_fire;

    // Handshake decode; alloc_ready_o looks only at registered count and
    // flush, so a same-cycle commit can never open a slot while full.
    always_comb begin
        full_o         = (cnt == FULL_CNT);
        empty_o        = (cnt == '0);
        count_o        = cnt;
        alloc_ready_o  = !full_o && !flush_i;
        alloc_idx_o    = issue_ptr;
        commit_valid_o = busy[commit_ptr] && done[commit_ptr] && !flush_i;
        commit_idx_o   = commit_ptr;
        commit_ex_o    = ex[commit_ptr];
        alloc_fire     = alloc_valid_i && alloc_ready_o;
        commit_fire    = commit_valid_o && commit_ack_i;
        // A slot being allocated this cycle is not yet busy, so a
        // writeback aimed at it is dropped here.
        wb_fire        = wb_valid_i && busy[wb_idx_i] && !done[wb_idx_i] && !flush_i;
    end

    // Pointer, occupancy and per-slot status update; flush overrides all.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_ptr  <= '0;
            commit_ptr <= '0;
            cnt        <= '0;
            busy       <= '0;
            done       <= '0;
            ex         <= '0;
        end else if (flush_i) begin
            issue_ptr  <= '0;
            commit_ptr <= '0;
            cnt        <= '0;
            busy       <= '0;
            done       <= '0;
            ex         <= '0;
        end else begin
            // Alloc, writeback and commit touch distinct slots in any
            // single cycle, so their updates never collide.
            if (alloc_fire) begin
                busy[issue_ptr] <= 1'b1;
                done[issue_ptr] <= 1'b0;
                ex[issue_ptr]   <= 1'b0;
                issue_ptr       <= issue_ptr + IDX_W'(1);
            end
            if (wb_fire) begin
                done[wb_idx_i] <= 1'b1;
                ex[wb_idx_i]   <= wb_ex_i;
            end
            if (commit_fire) begin
                busy[commit_ptr] <= 1'b0;
                done[commit_ptr] <= 1'b0;
                commit_ptr       <= commit_ptr + IDX_W'(1);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   cnt <= cnt + (IDX_W+1)'(1);
                2'b01:   cnt <= cnt - (IDX_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed-vector bench for scoreboard_ctrl with SB_ENTRIES = 8.
`timescale 1ns/1ps
module tb_scoreboard_ctrl;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          alloc_valid_i;
    logic          alloc_ready_o;
    logic [IW-1:0] alloc_idx_o;
    logic          wb_valid_i;
    logic [IW-1:0] wb_idx_i;
    logic          wb_ex_i;
    logic          commit_valid_o;
    logic [IW-1:0] commit_idx_o;
    logic          commit_ex_o;
    logic          commit_ack_i;
    logic [IW:0]   count_o;
    logic          empty_o;
    logic          full_o;

    int n_cmp = 0;
    int n_err = 0;

    scoreboard_ctrl #(.SB_ENTRIES(N), .IDX_W(IW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .alloc_valid_i  (alloc_valid_i),
        .alloc_ready_o  (alloc_ready_o),
        .alloc_idx_o    (alloc_idx_o),
        .wb_valid_i     (wb_valid_i),
        .wb_idx_i       (wb_idx_i),
        .wb_ex_i        (wb_ex_i),
        .commit_valid_o (commit_valid_o),
        .commit_idx_o   (commit_idx_o),
        .commit_ex_o    (commit_ex_o),
        .commit_ack_i   (commit_ack_i),
        .count_o        (count_o),
        .empty_o        (empty_o),
        .full_o         (full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then settle away from the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i       = 1'b0;
        alloc_valid_i = 1'b0;
        wb_valid_i    = 1'b0;
        wb_idx_i      = '0;
        wb_ex_i       = 1'b0;
        commit_ack_i  = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();

        // Reset held for 3 cycles
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready",   32'(alloc_ready_o), 1);
        chk("rst_aidx",    32'(alloc_idx_o), 0);
        chk("rst_cvalid",  32'(commit_valid_o), 0);
        chk("rst_cidx",    32'(commit_idx_o), 0);
        chk("rst_cex",     32'(commit_ex_o), 0);
        chk("rst_count",   32'(count_o), 0);
        chk("rst_empty",   32'(empty_o), 1);
        chk("rst_full",    32'(full_o), 0);
        rst_ni = 1'b1;
        tick();
        chk("post_rst_ready", 32'(alloc_ready_o), 1);

        // Fill to full: indices 0..7
        for (int i = 0; i < N; i++) begin
            alloc_valid_i = 1'b1;
            #1;
            chk("fill_idx", 32'(alloc_idx_o), 32'(i));
            chk("fill_ready", 32'(alloc_ready_o), 1);
            tick();
        end
        alloc_valid_i = 1'b0;
        #1;
        chk("full_flag",  32'(full_o), 1);
        chk("full_ready", 32'(alloc_ready_o), 0);
        chk("full_count", 32'(count_o), 8);
        // 9th request must not change state
        alloc_valid_i = 1'b1;
        tick();
        alloc_valid_i = 1'b0;
        chk("ninth_count", 32'(count_o), 8);
        chk("ninth_aidx",  32'(alloc_idx_o), 0);
        chk("ninth_cvalid", 32'(commit_valid_o), 0);

        // Exception writeback of the head while full
        wb_valid_i = 1'b1; wb_idx_i = 3'd0; wb_ex_i = 1'b1;
        tick();
        wb_valid_i = 1'b0; wb_ex_i = 1'b0;
        chk("ex_cvalid", 32'(commit_valid_o), 1);
        chk("ex_cidx",   32'(commit_idx_o), 0);
        chk("ex_flag",   32'(commit_ex_o), 1);
        // Alloc and ack together while full: only the commit happens
        alloc_valid_i = 1'b1; commit_ack_i = 1'b1;
        #1;
        chk("simul_ready", 32'(alloc_ready_o), 0);
        tick();
        alloc_valid_i = 1'b0; commit_ack_i = 1'b0;
        chk("simul_count", 32'(count_o), 7);
        chk("simul_cidx",  32'(commit_idx_o), 1);
        chk("simul_aidx",  32'(alloc_idx_o), 0);
        chk("simul_cex",   32'(commit_ex_o), 0);
        // Writeback to the just-freed slot 0 is ignored
        wb_valid_i = 1'b1; wb_idx_i = 3'd0;
        tick();
        wb_valid_i = 1'b0;
        chk("stale_wb_cvalid", 32'(commit_valid_o), 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("clear_count", 32'(count_o), 0);

        // Out-of-order writeback: allocate 0,1,2; wb 2, 0, 1 with ack held
        for (int i = 0; i < 3; i++) begin
            alloc_valid_i = 1'b1;
            tick();
        end
        alloc_valid_i = 1'b0;
        commit_ack_i  = 1'b1;
        wb_valid_i = 1'b1; wb_idx_i = 3'd2;
        tick();
        chk("ooo_no_commit", 32'(commit_valid_o), 0);
        wb_idx_i = 3'd0;
        tick();
        chk("ooo_c0_valid", 32'(commit_valid_o), 1);
        chk("ooo_c0_idx",   32'(commit_idx_o), 0);
        wb_idx_i = 3'd1;
        tick();
        wb_valid_i = 1'b0;
        chk("ooo_c1_valid", 32'(commit_valid_o), 1);
        chk("ooo_c1_idx",   32'(commit_idx_o), 1);
        tick();
        chk("ooo_c2_valid", 32'(commit_valid_o), 1);
        chk("ooo_c2_idx",   32'(commit_idx_o), 2);
        tick();
        commit_ack_i = 1'b0;
        chk("ooo_empty",    32'(empty_o), 1);
        chk("ooo_cvalid",   32'(commit_valid_o), 0);

        // Wrap-around: 3 in flight (3,4,5), then 10 commit+alloc rounds
        for (int i = 0; i < 3; i++) begin
            alloc_valid_i = 1'b1;
            tick();
        end
        alloc_valid_i = 1'b0;
        for (int j = 0; j < 10; j++) begin
            wb_valid_i = 1'b1; wb_idx_i = IW'((3 + j) % 8);
            tick();
            wb_valid_i = 1'b0;
            alloc_valid_i = 1'b1; commit_ack_i = 1'b1;
            #1;
            chk("wrap_cidx", 32'(commit_idx_o), 32'((3 + j) % 8));
            chk("wrap_aidx", 32'(alloc_idx_o), 32'((6 + j) % 8));
            tick();
            alloc_valid_i = 1'b0; commit_ack_i = 1'b0;
            chk("wrap_count", 32'(count_o), 3);
        end
        chk("wrap_end_cidx", 32'(commit_idx_o), 5);

        // Flush: build 5 in flight (5,6,7,0,1) with head done
        for (int i = 0; i < 2; i++) begin
            alloc_valid_i = 1'b1;
            tick();
        end
        alloc_valid_i = 1'b0;
        wb_valid_i = 1'b1; wb_idx_i = 3'd5;
        tick();
        chk("pre_flush_count",  32'(count_o), 5);
        chk("pre_flush_cvalid", 32'(commit_valid_o), 1);
        flush_i = 1'b1; commit_ack_i = 1'b1; alloc_valid_i = 1'b1;
        wb_valid_i = 1'b1; wb_idx_i = 3'd6;
        #1;
        chk("flush_cvalid", 32'(commit_valid_o), 0);
        chk("flush_ready",  32'(alloc_ready_o), 0);
        tick();
        idle_inputs();
        #1;
        chk("flush_count", 32'(count_o), 0);
        chk("flush_aidx",  32'(alloc_idx_o), 0);
        chk("flush_cidx",  32'(commit_idx_o), 0);
        chk("flush_cv2",   32'(commit_valid_o), 0);
        alloc_valid_i = 1'b1;
        #1;
        chk("post_flush_ready", 32'(alloc_ready_o), 1);
        chk("post_flush_aidx",  32'(alloc_idx_o), 0);
        tick();
        alloc_valid_i = 1'b0;
        chk("post_flush_count", 32'(count_o), 1);
        wb_valid_i = 1'b1; wb_idx_i = 3'd0;
        tick();
        wb_valid_i = 1'b0;
        chk("min_lat_cvalid", 32'(commit_valid_o), 1);
        chk("min_lat_cidx",   32'(commit_idx_o), 0);

        // Asynchronous reset mid-operation
        alloc_valid_i = 1'b1;
        tick();
        alloc_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_count",  32'(count_o), 0);
        chk("arst_empty",  32'(empty_o), 1);
        chk("arst_cvalid", 32'(commit_valid_o), 0);
        chk("arst_aidx",   32'(alloc_idx_o), 0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("arst_ready", 32'(alloc_ready_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
